// File: rtl/clk_wiz_0_pkg.sv
// Shared types and helpers for the clk_wiz_0 reset/lock sequencer.
package clk_wiz_0_pkg;

  typedef enum logic [2:0] {
    RST_MMCM  = 3'd0,
    WAIT_LOCK = 3'd1,
    STABLE    = 3'd2,
    RUN       = 3'd3,
    LOST      = 3'd4
  } state_t;

  // Width of the shared phase timer: enough bits for the longest phase, plus one.
  function automatic int timer_w(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return $clog2(m) + 1;
  endfunction

endpackage

// File: rtl/clk_wiz_0_rst_seq_if.sv
// Status/control bundle between the clocking network, the sequencer and user logic.
interface clk_wiz_0_rst_seq_if #(
  parameter int CNT_W = 8
);
  logic             locked;
  logic             input_clk_stopped;
  logic             clear_err;
  logic             mmcm_reset;
  logic             rst_out;
  logic             ready;
  logic             timeout_err;
  logic [CNT_W-1:0] relock_count;
  logic [2:0]       state;

  // Environment side: drives clocking-network status and error clear.
  modport master (
    output locked, input_clk_stopped, clear_err,
    input  mmcm_reset, rst_out, ready, timeout_err, relock_count, state
  );

  // Sequencer side.
  modport slave (
    input  locked, input_clk_stopped, clear_err,
    output mmcm_reset, rst_out, ready, timeout_err, relock_count, state
  );
endinterface

// File: rtl/clk_wiz_0_sync_bit.sv
// Multi-flop single-bit synchronizer for async status inputs, clears to 0 on reset.
module clk_wiz_0_sync_bit #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);
  logic [STAGES-1:0] ff;

  // Shift the async input through the flop chain.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) ff <= '0;
    else       ff <= {ff[STAGES-2:0], d};
  end

  assign q = ff[STAGES-1];
endmodule

// File: rtl/clk_wiz_0_rst_seq.sv
// Reset/lock sequencer for clk_wiz_0: pulses the MMCM reset, waits for a
// stable lock, then releases user reset; retries on timeout, relocks on loss.
module clk_wiz_0_rst_seq
  import clk_wiz_0_pkg::*;
#(
  parameter int MMCM_RST_CYCLES     = 16,
  parameter int LOCK_TIMEOUT_CYCLES = 65536,
  parameter int LOCK_STABLE_CYCLES  = 1024,
  parameter int SYNC_STAGES         = 2,
  parameter int CNT_W               = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  clk_wiz_0_rst_seq_if.slave   bus
);
  localparam int TW = timer_w(MMCM_RST_CYCLES, LOCK_TIMEOUT_CYCLES, LOCK_STABLE_CYCLES);
  localparam logic [TW-1:0] RST_LAST = TW'(MMCM_RST_CYCLES - 1);
  localparam logic [TW-1:0] TO_LAST  = TW'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [TW-1:0] STB_LAST = TW'(LOCK_STABLE_CYCLES - 1);

  logic             locked_s, stopped_s, lock_ok;
  state_t           state_q, state_n;
  logic [TW-1:0]    timer_q, timer_n;
  logic             to_set, relock_inc;
  logic             mmcm_reset_n, rst_out_n, ready_n;
  logic             mmcm_reset_q, rst_out_q, ready_q, timeout_q;
  logic [CNT_W-1:0] relock_q;

  clk_wiz_0_sync_bit #(.STAGES(SYNC_STAGES)) u_sync_locked (
    .clk(clk), .reset(reset), .d(bus.locked), .q(locked_s)
  );

  clk_wiz_0_sync_bit #(.STAGES(SYNC_STAGES)) u_sync_stopped (
    .clk(clk), .reset(reset), .d(bus.input_clk_stopped), .q(stopped_s)
  );

  assign lock_ok = locked_s && !stopped_s;

  // State and shared phase timer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= RST_MMCM;
      timer_q <= '0;
    end else begin
      state_q <= state_n;
      timer_q <= timer_n;
    end
  end

  // Next state; timer restarts on every transition and idles in RUN/LOST.
  always_comb begin
    state_n    = state_q;
    to_set     = 1'b0;
    relock_inc = 1'b0;
    case (state_q)
      RST_MMCM:  if (timer_q == RST_LAST) state_n = WAIT_LOCK;
      WAIT_LOCK: begin
        if (lock_ok) state_n = STABLE;
        else if (timer_q == TO_LAST) begin
          state_n = RST_MMCM;
          to_set  = 1'b1;
        end
      end
      STABLE: begin
        if (!lock_ok)                 state_n = WAIT_LOCK;
        else if (timer_q == STB_LAST) state_n = RUN;
      end
      RUN: begin
        if (!lock_ok) begin
          state_n    = LOST;
          relock_inc = 1'b1;
        end
      end
      LOST:    state_n = RST_MMCM;
      default: state_n = RST_MMCM;
    endcase
    timer_n = (state_n != state_q || state_q == RUN || state_q == LOST) ? '0 : timer_q + 1'b1;
  end

  // Output decode from the next state so the registered outputs line up with state_q.
  always_comb begin
    mmcm_reset_n = (state_n == RST_MMCM);
    rst_out_n    = (state_n != RUN);
    ready_n      = (state_n == RUN);
  end

  // Registered outputs, sticky timeout flag (set beats clear) and saturating relock count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mmcm_reset_q <= 1'b1;
      rst_out_q    <= 1'b1;
      ready_q      <= 1'b0;
      timeout_q    <= 1'b0;
      relock_q     <= '0;
    end else begin
      mmcm_reset_q <= mmcm_reset_n;
      rst_out_q    <= rst_out_n;
      ready_q      <= ready_n;
      if (to_set)             timeout_q <= 1'b1;
      else if (bus.clear_err) timeout_q <= 1'b0;
      if (relock_inc && relock_q != '1) relock_q <= relock_q + 1'b1;
    end
  end

  assign bus.mmcm_reset   = mmcm_reset_q;
  assign bus.rst_out      = rst_out_q;
  assign bus.ready        = ready_q;
  assign bus.timeout_err  = timeout_q;
  assign bus.relock_count = relock_q;
  assign bus.state        = state_q;
endmodule
